// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for a 2**ADDR_W-deep RAM FIFO: row addresses,
// qualified write/read enables, occupancy, full/empty/almost-full and sticky error flags.
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned AF_LEVEL = 28
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WrReq,
  input  logic              RdReq,
  input  logic              ClrErr,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              WrEn,
  output logic              RdEn,
  output logic              Full,
  output logic              Empty,
  output logic              AlmostFull,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              Underflow
);

  localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            full, empty;
  logic            wr_en, rd_en;
  logic [ADDR_W:0] count;

  // Flags are derived from the registered pointers; the extra MSB separates full from empty.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    count = wr_ptr_q - rd_ptr_q;
    // Enables are forced low for the whole time reset is held, not just after the edge.
    wr_en = Rst_n & WrReq & ~full;
    rd_en = Rst_n & RdReq & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_en};
    ovf_d    = (WrReq & full)  | (ovf_q & ~ClrErr);
    unf_d    = (RdReq & empty) | (unf_q & ~ClrErr);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    WrAddr     = wr_ptr_q[ADDR_W-1:0];
    RdAddr     = rd_ptr_q[ADDR_W-1:0];
    WrEn       = wr_en;
    RdEn       = rd_en;
    Full       = full;
    Empty      = empty;
    AlmostFull = (count >= AF_THR);
    Count      = count;
    Overflow   = ovf_q;
    Underflow  = unf_q;
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: stimulus pushes expected outputs per cycle,
// a monitor pops and compares them shortly after each input change.
module tb_fifo_ptr_ctrl;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned AF_LEVEL = 28;
  localparam int          DEPTH    = 32;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              WrReq = 1'b1;
  logic              RdReq = 1'b1;
  logic              ClrErr = 1'b0;
  logic [ADDR_W-1:0] WrAddr, RdAddr;
  logic              WrEn, RdEn, Full, Empty, AlmostFull, Overflow, Underflow;
  logic [ADDR_W:0]   Count;

  fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WrReq(WrReq), .RdReq(RdReq), .ClrErr(ClrErr),
    .WrAddr(WrAddr), .RdAddr(RdAddr), .WrEn(WrEn), .RdEn(RdEn),
    .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int wren, rden, full, empty, af, cnt, wa, ra, ovf, unf;
    int hand;  // hand-computed Count, -1 when not given
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a queue of written addresses gives occupancy and read order.
  int m_q[$];
  int m_wa = 0, m_ra = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rstn, input bit wr, input bit rd, input bit clr, input int hand);
    exp_t e;
    int   cnt, full, empty, wren, rden;
    @(negedge Clk);
    Rst_n = rstn; WrReq = wr; RdReq = rd; ClrErr = clr;
    if (!rstn) begin
      m_q.delete(); m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0;
    end
    cnt   = m_q.size();
    full  = (cnt == DEPTH) ? 1 : 0;
    empty = (cnt == 0) ? 1 : 0;
    wren  = (rstn && wr && !full) ? 1 : 0;
    rden  = (rstn && rd && !empty) ? 1 : 0;
    e.wren = wren; e.rden = rden; e.full = full; e.empty = empty;
    e.af = (cnt >= AF_LEVEL) ? 1 : 0; e.cnt = cnt; e.wa = m_wa; e.ra = m_ra;
    e.ovf = m_ovf; e.unf = m_unf; e.hand = hand;
    exp_q.push_back(e);
    if (rstn) begin
      m_ovf = ((wr && full) || (m_ovf && !clr)) ? 1 : 0;
      m_unf = ((rd && empty) || (m_unf && !clr)) ? 1 : 0;
      if (wren) begin m_q.push_back(m_wa); m_wa = (m_wa + 1) % DEPTH; end
      if (rden) begin void'(m_q.pop_front()); m_ra = (m_ra + 1) % DEPTH; end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("WrEn", int'(WrEn), e.wren);
        chk("RdEn", int'(RdEn), e.rden);
        chk("Full", int'(Full), e.full);
        chk("Empty", int'(Empty), e.empty);
        chk("AlmostFull", int'(AlmostFull), e.af);
        chk("Count", int'(Count), e.cnt);
        chk("WrAddr", int'(WrAddr), e.wa);
        chk("RdAddr", int'(RdAddr), e.ra);
        chk("Overflow", int'(Overflow), e.ovf);
        chk("Underflow", int'(Underflow), e.unf);
        if (e.hand >= 0) chk("Count_hand", int'(Count), e.hand);
      end
    end
  end

  initial begin : stimulus
    // Reset held with both requests high.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Fill to 32; the last write of the loop lands at address 31.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, i);
    // Write while full is refused and sets Overflow, then clear it.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32);
    // Simultaneous requests while full: only the read goes.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 31 - i);
    // Simultaneous requests while empty: only the write goes, Underflow sets.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 1'b1, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    // Random traffic with a reset dropped in the middle.
    for (int i = 0; i < 100; i++) begin
      if (i == 60) cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
      else cycle(1'b1, 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 9) == 0), -1);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, -1);
    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
